core_seq: RTL

- Instruction sequencer that sits directly upstream of the core and drives its 37-bit inst bus for one weight-stationary tile.
- Tile order:
  1. Stream col weight vectors from xmem into L0 and load them into the PE array.
  2. Stream a_len activation vectors through L0 and execute.
  3. Drain the OFIFO into pmem.
- The host only writes base addresses, a length and start, then waits for done.

---
 rtl/core_seq_pkg.sv | 48 ++++
 rtl/core_seq_cnt.sv | 28 ++
 rtl/core_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the core instruction sequencer: tile geometry,
// inst bus field map, idle instruction word and FSM state encoding.
package core_seq_pkg;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int ADDR_W = 11;
    // Idle gap after weight load must cover the array fill/skew (row+col).
    localparam int SETTLE = (ROW + COL > 16) ? ROW + COL : 16;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int INST_W = 37;

    localparam int LOAD     = 0;
    localparam int EXEC     = 1;
    localparam int L0_WR    = 2;
    localparam int L0_RD    = 3;
    localparam int IFIFO_RD = 4;
    localparam int IFIFO_WR = 5;
    localparam int OFIFO_RD = 6;
    localparam int A_XMEM   = 7;
    localparam int WEN_XMEM = 18;
    localparam int CEN_XMEM = 19;
    localparam int A_PMEM   = 20;
    localparam int WEN_PMEM = 31;
    localparam int CEN_PMEM = 32;
    localparam int ACC      = 33;
    localparam int D_XMEM   = 35;

    localparam logic [INST_W-1:0] IDLE_INST = 37'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        WRD,
        WLD,
        WSET,
        ARD,
        AEX,
        DRN,
        DONE
    } state_t;

    // Modulo-2^ADDR_W address: base plus a counter offset, carry dropped.
    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  off);
        return ADDR_W'({1'b0, base} + off);
    endfunction

endpackage

// File: rtl/core_seq_cnt.sv
// Loadable up-counter; tc flags the last count before reaching limit.
module core_seq_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = ((count + W'(1)) == limit);

endmodule

// File: rtl/core_seq.sv
// Weight-stationary tile sequencer: weight read/load, settle, activation
// read/execute, then OFIFO drain into pmem, all on a registered inst word.
module core_seq
    import core_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] a_len,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] w_base_q, a_base_q, a_len_q, p_base_q;
    logic              acc_q;
    logic              accept;
    logic [INST_W-1:0] inst_d;
    logic              busy_d, done_d;

    logic              ph_load, ph_en, ph_tc;
    logic [CNT_W-1:0]  ph_limit, ph_cnt;
    logic              wr_load, wr_en, wr_tc;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  a_len_ext;

    assign a_len_ext = {1'b0, a_len_q};

    // Phase counter: read/load/settle/execute steps, and OFIFO pops in drain.
    core_seq_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val ('0),
        .en       (ph_en),
        .limit    (ph_limit),
        .count    (ph_cnt),
        .tc       (ph_tc)
    );

    core_seq_cnt #(.W(CNT_W)) u_write_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (wr_load),
        .load_val ('0),
        .en       (wr_en),
        .limit    (a_len_ext),
        .count    (wr_cnt),
        .tc       (wr_tc)
    );

    // NOTE: every always_comb output gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d  = state_q;
        inst_d   = IDLE_INST;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        accept   = 1'b0;
        ph_load  = 1'b0;
        ph_en    = 1'b0;
        ph_limit = CNT_W'(COL);
        wr_load  = 1'b0;
        wr_en    = 1'b0;

        // xmem Q arrives one cycle after the read strobe currently on the bus.
        inst_d[L0_WR] = ~inst[CEN_XMEM];

        unique case (state_q)
            IDLE: begin
                busy_d  = start;
                ph_load = 1'b1;
                wr_load = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = WRD;
                end
            end
            WRD: begin
                inst_d[CEN_XMEM]             = 1'b0;
                inst_d[A_XMEM +: ADDR_W]     = addr_add(w_base_q, ph_cnt);
                ph_en                        = 1'b1;
                if (ph_tc) begin
                    ph_load = 1'b1;
                    state_d = WLD;
                end
            end
            WLD: begin
                inst_d[L0_RD] = 1'b1;
                inst_d[LOAD]  = 1'b1;
                ph_en         = 1'b1;
                if (ph_tc) begin
                    ph_load = 1'b1;
                    state_d = WSET;
                end
            end
            WSET: begin
                ph_limit = CNT_W'(SETTLE);
                ph_en    = 1'b1;
                if (ph_tc) begin
                    ph_load = 1'b1;
                    state_d = (a_len_q != '0) ? ARD : DONE;
                end
            end
            ARD: begin
                ph_limit                 = a_len_ext;
                inst_d[CEN_XMEM]         = 1'b0;
                inst_d[A_XMEM +: ADDR_W] = addr_add(a_base_q, ph_cnt);
                ph_en                    = 1'b1;
                if (ph_tc) begin
                    ph_load = 1'b1;
                    state_d = AEX;
                end
            end
            AEX: begin
                ph_limit      = a_len_ext;
                inst_d[L0_RD] = 1'b1;
                inst_d[EXEC]  = 1'b1;
                ph_en         = 1'b1;
                if (ph_tc) begin
                    ph_load = 1'b1;
                    state_d = DRN;
                end
            end
            DRN: begin
                // Pop whenever data is there and pops are still owed; the
                // pmem write for a pop goes out on the following word.
                ph_limit         = a_len_ext;
                ph_en            = ofifo_valid && (ph_cnt < a_len_ext);
                inst_d[OFIFO_RD] = ph_en;
                if (inst[OFIFO_RD]) begin
                    inst_d[CEN_PMEM]         = 1'b0;
                    inst_d[WEN_PMEM]         = 1'b0;
                    inst_d[A_PMEM +: ADDR_W] = addr_add(p_base_q, wr_cnt);
                    inst_d[ACC]              = acc_q;
                    wr_en                    = 1'b1;
                    if (wr_tc) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            inst     <= IDLE_INST;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_base_q <= '0;
            a_base_q <= '0;
            a_len_q  <= '0;
            p_base_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            inst    <= inst_d;
            busy    <= busy_d;
            done    <= done_d;
            if (accept) begin
                w_base_q <= w_base;
                a_base_q <= a_base;
                a_len_q  <= a_len;
                p_base_q <= p_base;
                acc_q    <= acc_en;
            end
        end
    end

endmodule
